// File: rtl/slp_infer_seq.sv
// -----------------------------------------------------------------------------
// slp_infer_seq
//
// Sequential forward-pass (inference) engine for a single-layer perceptron.
// A request carries one input vector and its weight vector. Bias is the last
// weight entry. The engine walks all WEIGHT products through one shared
// multiply-accumulate. It then applies a step activation and presents the
// result through a valid/ready handshake. The infer output is the value the
// training path consumes as the inference result when it computes the error.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   in_valid   request valid
//   in_ready   engine idle and able to accept a request
//   in         IN x I_PREC input vector, in[0] in the least significant slot
//   weight     WEIGHT x W_PREC weights, weight[IN] is the bias
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   infer      step activation: 1.0 in P format, or 0
//   sum        weighted sum rescaled to P format and saturated
//   ovf        sum was clamped (either sign)
//   busy       engine is not idle
// -----------------------------------------------------------------------------

package slp_infer_seq_pkg;

  typedef enum logic [1:0] {
    DT_INT  = 2'd0,
    DT_BOOL = 2'd1,
    DT_FXP  = 2'd2,
    DT_FP   = 2'd3
  } dtype_e;

  typedef struct packed {
    dtype_e dtype;
    int     prec;
    int     frac;
  } dconf_t;

endpackage

`ifndef DEF_DCONF
`define DEF_DCONF slp_infer_seq_pkg::dconf_t'{dtype: slp_infer_seq_pkg::DT_INT, prec: 8, frac: 0}
`endif

module slp_infer_seq
  import slp_infer_seq_pkg::*;
#(
  parameter int     IN     = 8,
  parameter dconf_t I_CONF = `DEF_DCONF,
  parameter dconf_t W_CONF = `DEF_DCONF,
  parameter dconf_t P_CONF = `DEF_DCONF,
  parameter int     I_PREC = I_CONF.prec,
  parameter int     W_PREC = W_CONF.prec,
  parameter int     P_PREC = P_CONF.prec,
  parameter int     WEIGHT = IN + 1,
  parameter int     ACC_W  = I_PREC + W_PREC + $clog2(WEIGHT) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN-1:0][I_PREC-1:0]     in,
  input  logic [WEIGHT-1:0][W_PREC-1:0] weight,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [P_PREC-1:0]             infer,
  output logic [P_PREC-1:0]             sum,
  output logic                          ovf,
  output logic                          busy
);

  localparam int I_FRAC = I_CONF.frac;
  localparam int W_FRAC = W_CONF.frac;
  localparam int P_FRAC = P_CONF.frac;
  // Product scale is I_FRAC+W_FRAC; this many low bits are dropped to land in P format.
  localparam int SHIFT  = I_FRAC + W_FRAC - P_FRAC;
  localparam int IDX_W  = $clog2(WEIGHT + 1);

  // Operand that multiplies the bias weight: 1.0 in the input format.
  localparam logic [I_PREC-1:0] CONST1 = I_PREC'(1) << I_FRAC;
  localparam logic [P_PREC-1:0] P_ONE  = P_PREC'(1) << P_FRAC;

  // Saturation limits, both at accumulator width and at output width.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-P_PREC+1){1'b0}}, {(P_PREC-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-P_PREC+1){1'b1}}, {(P_PREC-1){1'b0}}};
  localparam logic [P_PREC-1:0]       SUM_MAX = {1'b0, {(P_PREC-1){1'b1}}};
  localparam logic [P_PREC-1:0]       SUM_MIN = {1'b1, {(P_PREC-1){1'b0}}};

  // Configurations the datapath cannot honour are rejected at elaboration.
  if (I_CONF.dtype == DT_FP || W_CONF.dtype == DT_FP || P_CONF.dtype == DT_FP) begin : g_fp_check
    $error("slp_infer_seq: floating-point data type is not supported");
  end
  if (I_FRAC + W_FRAC < P_FRAC) begin : g_frac_check
    $error("slp_infer_seq: I_CONF.frac + W_CONF.frac must be >= P_CONF.frac");
  end
  if (ACC_W < P_PREC) begin : g_width_check
    $error("slp_infer_seq: accumulator narrower than output format");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic [IN-1:0][I_PREC-1:0]       x_q, x_d;
  logic [WEIGHT-1:0][W_PREC-1:0]   w_q, w_d;
  logic [P_PREC-1:0]               infer_q, infer_d;
  logic [P_PREC-1:0]               sum_q, sum_d;
  logic                            ovf_q, ovf_d;

  logic [I_PREC-1:0]               x_op;
  logic [W_PREC-1:0]               w_op;
  logic signed [ACC_W-1:0]         x_ext;
  logic signed [ACC_W-1:0]         w_ext;
  logic signed [ACC_W-1:0]         prod;
  logic signed [ACC_W-1:0]         acc_sum;
  logic signed [ACC_W-1:0]         acc_shr;
  logic [P_PREC-1:0]               sum_sat;
  logic                            ovf_sat;

  // Shared MAC datapath: pick the operand pair for the current index and
  // extend both to full accumulator width so nothing is rounded before the
  // final rescale. Index IN selects the bias weight against CONST1. The
  // rescaled, clamped view of the running total is ready for the last step.
  always_comb begin
    x_op = CONST1;
    for (int i = 0; i < IN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_op = x_q[i];
      end
    end
    w_op = '0;
    for (int i = 0; i < WEIGHT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_op = w_q[i];
      end
    end
    x_ext   = {{(ACC_W-I_PREC){x_op[I_PREC-1]}}, x_op};
    w_ext   = {{(ACC_W-W_PREC){w_op[W_PREC-1]}}, w_op};
    prod    = x_ext * w_ext;
    acc_sum = acc_q + prod;
    acc_shr = acc_sum >>> SHIFT;
    ovf_sat = 1'b0;
    if (acc_shr > ACC_MAX) begin
      sum_sat = SUM_MAX;
      ovf_sat = 1'b1;
    end else if (acc_shr < ACC_MIN) begin
      sum_sat = SUM_MIN;
      ovf_sat = 1'b1;
    end else begin
      sum_sat = acc_shr[P_PREC-1:0];
    end
  end

  // Control: IDLE latches the request, MAC steps one product per cycle, and
  // DONE holds the registered result until the consumer takes it. Result
  // registers load only on the final MAC step, so they stay stable under
  // backpressure. The activation uses the unrescaled accumulator sign.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    infer_d = infer_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in;
          w_d     = weight;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WEIGHT - 1)) begin
          state_d = S_DONE;
          infer_d = acc_sum[ACC_W-1] ? '0 : P_ONE;
          sum_d   = sum_sat;
          ovf_d   = ovf_sat;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset wins over any handshake in the same
  // cycle and drops an in-flight request without producing a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      infer_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      infer_q <= infer_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign infer     = infer_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_slp_infer_seq.sv
// -----------------------------------------------------------------------------
// tb_slp_infer_seq
//
// Testbench for slp_infer_seq. It builds two instances:
//   dut0 - INT, 8-bit, frac 0, IN=2
//   dut1 - FXP, 8-bit, frac 4, IN=1 (two MAC cycles)
// A driver pushes the expected response for each accepted request into a
// per-instance queue. The expected value comes from a plain-arithmetic
// perceptron model. A monitor per instance compares every presented result
// against the head of its queue.
// -----------------------------------------------------------------------------

module tb_slp_infer_seq;
  import slp_infer_seq_pkg::*;

  localparam dconf_t INT_CONF = '{dtype: DT_INT, prec: 8, frac: 0};
  localparam dconf_t FXP_CONF = '{dtype: DT_FXP, prec: 8, frac: 4};

  typedef struct packed {
    logic [7:0] sum;
    logic [7:0] infer;
    logic       ovf;
    int         acceptEdge;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic            inValid0, inReady0, outValid0, outReady0, ovf0, busy0;
  logic [1:0][7:0] in0;
  logic [2:0][7:0] w0;
  logic [7:0]      infer0, sum0;

  logic            inValid1, inReady1, outValid1, outReady1, ovf1, busy1;
  logic [0:0][7:0] in1;
  logic [1:0][7:0] w1;
  logic [7:0]      infer1, sum1;

  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cycle       = 0;
  exp_t sb[2][$];
  bit   prevValid[2];

  always #5 clk = ~clk;

  // Count clock edges, so latency can be measured in whole cycles.
  always @(posedge clk) cycle <= cycle + 1;

  slp_infer_seq #(.IN(2), .I_CONF(INT_CONF), .W_CONF(INT_CONF), .P_CONF(INT_CONF)) dut0 (
    .clk(clk), .reset(reset), .in_valid(inValid0), .in_ready(inReady0),
    .in(in0), .weight(w0), .out_valid(outValid0), .out_ready(outReady0),
    .infer(infer0), .sum(sum0), .ovf(ovf0), .busy(busy0)
  );

  slp_infer_seq #(.IN(1), .I_CONF(FXP_CONF), .W_CONF(FXP_CONF), .P_CONF(FXP_CONF)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inValid1), .in_ready(inReady1),
    .in(in1), .weight(w1), .out_valid(outValid1), .out_ready(outReady1),
    .infer(infer1), .sum(sum1), .ovf(ovf1), .busy(busy1)
  );

  // Single comparison point: counts and reports.
  task automatic checkVal(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s dut%0d @cycle %0d: got 0x%0h, expected 0x%0h", name, id, cycle, act, exp);
    end
  endtask

  // Perceptron reference model: bias input is 1.0 in the input format. The
  // rescale floors toward -inf and the result is clamped to 8-bit signed.
  // The activation uses the sign of the unscaled sum.
  function automatic exp_t refModel(input int id, input logic [1:0][7:0] xv, input logic [2:0][7:0] wv);
    exp_t   e;
    int     n;
    int     frac;
    longint acc;
    longint d;
    longint s;
    n    = (id == 0) ? 2 : 1;
    frac = (id == 0) ? 0 : 4;
    acc  = 0;
    for (int i = 0; i < n; i++) begin
      acc += longint'($signed(xv[i])) * longint'($signed(wv[i]));
    end
    acc += (longint'(1) <<< frac) * longint'($signed(wv[n]));
    d = longint'(1) <<< (frac + frac - frac);
    s = acc / d;
    if ((acc % d) != 0 && acc < 0) s -= 1;
    e.ovf = 1'b0;
    if (s > 127) begin
      e.sum = 8'h7F;
      e.ovf = 1'b1;
    end else if (s < -128) begin
      e.sum = 8'h80;
      e.ovf = 1'b1;
    end else begin
      e.sum = s[7:0];
    end
    e.infer      = (acc >= 0) ? 8'(1 << frac) : 8'h00;
    e.acceptEdge = 0;
    return e;
  endfunction

  // Offer one request and hold it until the engine accepts it. Then drop
  // in_valid and scramble the operand pins, which the engine must ignore.
  task automatic applyStimulus(input int id, input logic [1:0][7:0] xv, input logic [2:0][7:0] wv);
    exp_t e;
    bit   took;
    int   waited;
    e = refModel(id, xv, wv);
    @(negedge clk);
    if (id == 0) begin
      in0 = xv; w0 = wv; inValid0 = 1'b1;
    end else begin
      in1[0] = xv[0]; w1 = wv[1:0]; inValid1 = 1'b1;
    end
    took   = 1'b0;
    waited = 0;
    while (!took && waited < 200) begin
      took = (id == 0) ? inReady0 : inReady1;
      if (took) begin
        e.acceptEdge = cycle + 1;
        sb[id].push_back(e);
      end
      @(posedge clk);
      if (!took) begin
        @(negedge clk);
        waited++;
      end
    end
    if (!took) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL accept-timeout dut%0d: got no in_ready, expected accept within 200 cycles", id);
    end
    @(negedge clk);
    if (id == 0) begin
      inValid0 = 1'b0; in0 = 16'($urandom); w0 = 24'($urandom);
    end else begin
      inValid1 = 1'b0; in1 = 8'($urandom); w1 = 16'($urandom);
    end
  endtask

  // Monitor body: while a result is presented it must match the queue head.
  // in_ready must be low. The first valid cycle must be exactly WEIGHT edges
  // after the accepting edge. A handshake pops the head.
  task automatic checkOutput(input int id, input logic ov, input logic ordy, input logic ird,
                             input logic [7:0] s, input logic [7:0] inf, input logic ovfl);
    exp_t e;
    int   weightCnt;
    weightCnt = (id == 0) ? 3 : 2;
    if (reset) begin
      prevValid[id] = 1'b0;
      return;
    end
    if (ov) begin
      checkVal("in_ready_in_done", id, 32'(ird), 32'd0);
      if (sb[id].size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected-result dut%0d @cycle %0d: got out_valid=1, expected no pending result", id, cycle);
      end else begin
        e = sb[id][0];
        if (!prevValid[id]) checkVal("latency", id, 32'(cycle - e.acceptEdge), 32'(weightCnt));
        checkVal("sum", id, 32'(s), 32'(e.sum));
        checkVal("infer", id, 32'(inf), 32'(e.infer));
        checkVal("ovf", id, 32'(ovfl), 32'(e.ovf));
        if (ordy) void'(sb[id].pop_front());
      end
    end
    prevValid[id] = ov;
  endtask

  always @(negedge clk) begin
    #1;
    checkOutput(0, outValid0, outReady0, inReady0, sum0, infer0, ovf0);
  end

  always @(negedge clk) begin
    #1;
    checkOutput(1, outValid1, outReady1, inReady1, sum1, infer1, ovf1);
  end

  // Wait until every expected result of an instance has been popped. Then,
  // one cycle after the pop, the engine must be back in IDLE.
  task automatic waitDrain(input int id);
    int waited;
    waited = 0;
    while (sb[id].size() != 0 && waited < 300) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (sb[id].size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain-timeout dut%0d: got %0d pending, expected 0", id, sb[id].size());
    end
    @(negedge clk);
    #2;
    checkVal("in_ready_after_pop", id, 32'((id == 0) ? inReady0 : inReady1), 32'd1);
    checkVal("out_valid_after_pop", id, 32'((id == 0) ? outValid0 : outValid1), 32'd0);
  endtask

  // Random traffic for one instance: random operands, gaps and backpressure.
  task automatic randomTraffic(input int id, input int count);
    logic [1:0][7:0] xv;
    logic [2:0][7:0] wv;
    for (int k = 0; k < count; k++) begin
      xv = 16'($urandom);
      wv = 24'($urandom);
      applyStimulus(id, xv, wv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset state, then the directed cases, backpressure, FXP,
  // reset while in MAC, and finally concurrent random traffic.
  initial begin
    bit randomDone;
    reset     = 1'b1;
    inValid0  = 1'b0; inValid1  = 1'b0;
    outReady0 = 1'b1; outReady1 = 1'b1;
    in0 = '0; w0 = '0; in1 = '0; w1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    checkVal("reset_in_ready", 0, 32'(inReady0), 32'd1);
    checkVal("reset_out_valid", 0, 32'(outValid0), 32'd0);
    checkVal("reset_busy", 0, 32'(busy0), 32'd0);
    checkVal("reset_sum", 0, 32'(sum0), 32'd0);
    checkVal("reset_infer", 0, 32'(infer0), 32'd0);
    checkVal("reset_ovf", 0, 32'(ovf0), 32'd0);
    checkVal("reset_in_ready", 1, 32'(inReady1), 32'd1);
    checkVal("reset_busy", 1, 32'(busy1), 32'd0);

    // Directed INT cases: positive, negative, zero and both saturations.
    applyStimulus(0, {8'hFE, 8'h03}, {8'hFD, 8'h01, 8'h02});
    waitDrain(0);
    applyStimulus(0, {8'hFE, 8'h03}, {8'hFB, 8'h01, 8'h02});
    waitDrain(0);
    applyStimulus(0, {8'hFE, 8'h03}, {8'hFC, 8'h01, 8'h02});
    waitDrain(0);
    applyStimulus(0, {8'h7F, 8'h7F}, {8'h00, 8'h7F, 8'h7F});
    waitDrain(0);
    applyStimulus(0, {8'h80, 8'h80}, {8'h00, 8'h7F, 8'h7F});
    waitDrain(0);

    // Backpressure: the result is held for 5 cycles, and a second request
    // offered meanwhile must wait for the pop.
    outReady0 = 1'b0;
    applyStimulus(0, {8'h10, 8'hF0}, {8'h05, 8'h03, 8'h02});
    fork
      applyStimulus(0, {8'h01, 8'h02}, {8'h01, 8'h01, 8'h01});
      begin
        int w;
        w = 0;
        while (!outValid0 && w < 50) begin
          @(negedge clk);
          w++;
        end
        repeat (5) @(negedge clk);
        outReady0 = 1'b1;
      end
    join
    waitDrain(0);

    // FXP, IN=1: 1.5 * 0.5 + 1.0 * (-0.5) = 0.25.
    applyStimulus(1, {8'h00, 8'h18}, {8'h00, 8'hF8, 8'h08});
    waitDrain(1);

    // Reset one cycle after accept must discard the request.
    applyStimulus(0, {8'h05, 8'h07}, {8'h01, 8'h02, 8'h03});
    reset = 1'b1;
    sb[0].delete();
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkVal("mid_reset_busy", 0, 32'(busy0), 32'd0);
    checkVal("mid_reset_in_ready", 0, 32'(inReady0), 32'd1);
    checkVal("mid_reset_out_valid", 0, 32'(outValid0), 32'd0);
    repeat (6) @(negedge clk);
    applyStimulus(0, {8'h05, 8'h07}, {8'h01, 8'h02, 8'h03});
    waitDrain(0);

    // Concurrent random traffic on both instances with random backpressure.
    randomDone = 1'b0;
    fork
      begin
        fork
          randomTraffic(0, 40);
          randomTraffic(1, 40);
        join
        randomDone = 1'b1;
      end
      begin
        while (!randomDone) begin
          @(negedge clk);
          outReady0 = ($urandom_range(0, 3) != 0);
          outReady1 = ($urandom_range(0, 2) != 0);
        end
        outReady0 = 1'b1;
        outReady1 = 1'b1;
      end
    join
    waitDrain(0);
    waitDrain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
